// File: rtl/boot_rom_arbiter.sv
// Shares one synchronous boot-ROM read port between two requesters with round-robin
// arbitration, byte-to-word address translation, range checking and one-cycle responses.
module boot_rom_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int BADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_i,
    input  logic [2*BADDR_WIDTH-1:0] addr_i,
    output logic [1:0]               gnt_o,
    output logic [1:0]               rvalid_o,
    output logic [63:0]              rdata_o,
    output logic [1:0]               err_o,
    output logic                     rom_en_o,
    output logic [ADDR_WIDTH-1:0]    rom_addr_o,
    input  logic [31:0]              rom_rdata_i
);
    logic [BADDR_WIDTH-1:0] port_addr [2];
    logic [BADDR_WIDTH-1:0] sel_addr;
    logic                   grant_valid;
    logic                   grant_port;
    logic                   in_range;
    logic                   addr_unused;

    logic rr_q;
    logic resp_v_q;
    logic resp_port_q;
    logic resp_err_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic        resp_here;
            logic [31:0] rdata_q;
            logic        err_q;

            assign port_addr[gi] = addr_i[gi*BADDR_WIDTH +: BADDR_WIDTH];
            assign resp_here     = resp_v_q && (resp_port_q == 1'(gi));
            assign rvalid_o[gi]  = resp_here;

            // ROM data arrives during the response cycle, so it is forwarded straight
            // through and held in rdata_q from the following edge onwards.
            assign rdata_o[gi*32 +: 32] = resp_here ? (resp_err_q ? 32'h0 : rom_rdata_i) : rdata_q;
            assign err_o[gi]            = resp_here ? resp_err_q : err_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b0;
                end else if (resp_here) begin
                    rdata_q <= resp_err_q ? 32'h0 : rom_rdata_i;
                    err_q   <= resp_err_q;
                end
            end
        end
    endgenerate

    // Round-robin pointer only matters when both ports request at once.
    assign grant_valid = |req_i;
    assign grant_port  = (&req_i) ? rr_q : req_i[1];
    assign gnt_o       = {grant_valid & grant_port, grant_valid & ~grant_port};
    assign sel_addr    = port_addr[grant_port];
    assign addr_unused = ^sel_addr[1:0];

    generate
        if (BADDR_WIDTH > ADDR_WIDTH + 2) begin : g_range
            assign in_range = ~|sel_addr[BADDR_WIDTH-1:ADDR_WIDTH+2];
        end else begin : g_no_range
            assign in_range = 1'b1;
        end
    endgenerate

    assign rom_en_o   = grant_valid & in_range;
    assign rom_addr_o = grant_valid ? sel_addr[ADDR_WIDTH+1:2] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= 1'b0;
            resp_v_q    <= 1'b0;
            resp_port_q <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            resp_v_q <= grant_valid;
            if (grant_valid) begin
                rr_q        <= ~grant_port;
                resp_port_q <= grant_port;
                resp_err_q  <= ~in_range;
            end
        end
    end
endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Directed bench for boot_rom_arbiter: a synchronous ROM model feeds the DUT and each
// scenario task checks grants, ROM controls and per-port responses against fixed values.
module tb_boot_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [63:0] addr = 64'h0;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [63:0] rdata;
    logic [1:0]  err;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata = 32'h0;
    logic [31:0] mem [1024];

    int errors = 0;
    int checks = 0;

    boot_rom_arbiter #(.ADDR_WIDTH(10), .BADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .rom_en_o(rom_en),
        .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_rdata <= mem[rom_addr];

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", err); end
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (rom_en !== 1'b0 || rom_addr !== 10'd0) begin errors++; $display("FAIL reset_rom got_en=%b got_addr=%0d exp=0/0", rom_en, rom_addr); end
        rst_n = 1'b1;
        $display("reset: outputs idle");
    endtask

    task automatic test_single();
        @(negedge clk); req = 2'b01; addr[31:0] = 32'h8; #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got=%b exp=01", gnt); end
        checks++; if (rom_en !== 1'b1 || rom_addr !== 10'd2) begin errors++; $display("FAIL single_rom got_en=%b got_addr=%0d exp=1/2", rom_en, rom_addr); end
        @(negedge clk); req = 2'b00; #1;
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL single_rvalid got=%b exp=01", rvalid); end
        checks++; if (rdata[31:0] !== 32'hDEADBEEF || err[0] !== 1'b0) begin errors++; $display("FAIL single_data got=%h err=%b exp=deadbeef/0", rdata[31:0], err[0]); end
        $display("single: port0 addr=0x8 rdata=%h", rdata[31:0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (rvalid !== 2'b00 || rdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold%0d got_rvalid=%b got_data=%h exp=00/deadbeef", i, rvalid, rdata[31:0]); end
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
        @(negedge clk); req = 2'b11; addr = {32'hC, 32'h0}; #1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            if (k < 4) begin
                checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL contention_gnt%0d got=%b exp=%b", k, gnt, exp_gnt); end
            end
            if (k > 0) begin
                if (k % 2 == 1) begin
                    checks++; if (rvalid !== 2'b01 || rdata[31:0] !== 32'hC0DE0000) begin errors++; $display("FAIL contention_p0_%0d got_rvalid=%b got_data=%h exp=01/c0de0000", k, rvalid, rdata[31:0]); end
                end else begin
                    checks++; if (rvalid !== 2'b10 || rdata[63:32] !== 32'hC0DE0003) begin errors++; $display("FAIL contention_p1_%0d got_rvalid=%b got_data=%h exp=10/c0de0003", k, rvalid, rdata[63:32]); end
                end
            end
            $display("contention: cycle %0d gnt=%b rvalid=%b", k, gnt, rvalid);
            @(negedge clk); if (k == 3) req = 2'b00; #1;
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk); req = 2'b10; addr[63:32] = 32'h1000; #1;
        checks++; if (gnt !== 2'b10 || rom_en !== 1'b0) begin errors++; $display("FAIL oor_grant got_gnt=%b got_en=%b exp=10/0", gnt, rom_en); end
        @(negedge clk); addr[63:32] = 32'h4; #1;
        checks++; if (rvalid !== 2'b10 || err[1] !== 1'b1 || rdata[63:32] !== 32'h0) begin errors++; $display("FAIL oor_resp got_rvalid=%b err=%b data=%h exp=10/1/0", rvalid, err[1], rdata[63:32]); end
        checks++; if (err[0] !== 1'b0 || rdata[31:0] !== 32'hC0DE0000) begin errors++; $display("FAIL oor_other got_err=%b data=%h exp=0/c0de0000", err[0], rdata[31:0]); end
        $display("out_of_range: port1 addr=0x1000 err=%b", err[1]);
        checks++; if (gnt !== 2'b10 || rom_en !== 1'b1 || rom_addr !== 10'd1) begin errors++; $display("FAIL oor_next_grant got_gnt=%b en=%b addr=%0d exp=10/1/1", gnt, rom_en, rom_addr); end
        @(negedge clk); req = 2'b00; #1;
        checks++; if (rvalid !== 2'b10 || err[1] !== 1'b0 || rdata[63:32] !== 32'hC0DE0001) begin errors++; $display("FAIL oor_clear got_rvalid=%b err=%b data=%h exp=10/0/c0de0001", rvalid, err[1], rdata[63:32]); end
        @(negedge clk); #1;
        checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL oor_clear_hold got=%b exp=0", err[1]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [4];
        exp_data[0] = 32'hC0DE0000; exp_data[1] = 32'hC0DE0001;
        exp_data[2] = 32'hDEADBEEF; exp_data[3] = 32'hC0DE0003;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin req = 2'b01; addr[31:0] = 32'(4 * k); end else req = 2'b00;
            #1;
            if (k > 0) begin
                checks++; if (rvalid !== 2'b01 || rdata[31:0] !== exp_data[k-1]) begin errors++; $display("FAIL b2b_%0d got_rvalid=%b data=%h exp=01/%h", k - 1, rvalid, rdata[31:0], exp_data[k-1]); end
                checks++; if (rdata[63:32] !== 32'hC0DE0001) begin errors++; $display("FAIL b2b_p1_%0d got=%h exp=c0de0001", k - 1, rdata[63:32]); end
                $display("back_to_back: word %0d rdata=%h", k - 1, rdata[31:0]);
            end
        end
    endtask

    task automatic test_byte_offset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) begin req = 2'b01; addr[31:0] = 32'(5 + k); end else req = 2'b00;
            #1;
            if (k < 3) begin
                checks++; if (rom_addr !== 10'd1) begin errors++; $display("FAIL offset_addr%0d got=%0d exp=1", k, rom_addr); end
            end
            if (k > 0) begin
                checks++; if (rvalid !== 2'b01 || rdata[31:0] !== 32'hC0DE0001) begin errors++; $display("FAIL offset_data%0d got_rvalid=%b data=%h exp=01/c0de0001", k, rvalid, rdata[31:0]); end
                $display("byte_offset: addr=0x%0h rdata=%h", 4 + k, rdata[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); req = 2'b10; addr[63:32] = 32'h8; #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL midrst_gnt got=%b exp=10", gnt); end
        #2; rst_n = 1'b0; req = 2'b00; #1;
        checks++; if ({gnt, rvalid, err, rom_en, rom_addr} !== 17'h0 || rdata !== 64'h0) begin errors++; $display("FAIL midrst_outputs got_gnt=%b rvalid=%b err=%b en=%b addr=%0d data=%h exp=all zero", gnt, rvalid, err, rom_en, rom_addr, rdata); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL midrst_rvalid0 got=%b exp=00", rvalid); end
        @(negedge clk); req = 2'b11; addr = {32'h4, 32'h0}; #1;
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL midrst_rvalid1 got=%b exp=00", rvalid); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_first_gnt got=%b exp=01", gnt); end
        @(negedge clk); req = 2'b00; #1;
        checks++; if (rvalid !== 2'b01 || rdata[31:0] !== 32'hC0DE0000) begin errors++; $display("FAIL midrst_resp got_rvalid=%b data=%h exp=01/c0de0000", rvalid, rdata[31:0]); end
        $display("reset_mid: first grant after reset gnt=01 rdata=%h", rdata[31:0]);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
        mem[2] = 32'hDEADBEEF;
        test_reset();
        test_single();
        test_contention();
        test_out_of_range();
        test_back_to_back();
        test_byte_offset();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/boot_rom_arbiter.md
# boot_rom_arbiter

Two-port arbiter and sequencer for the single-ported synchronous boot ROM. It shares one ROM read port between the core instruction-fetch port (port 0) and the AXI/debug slave port (port 1). It translates byte addresses to ROM word addresses, flags out-of-range accesses, and returns per-port read data with a fixed one-cycle latency. It sits between the two requesters and the boot ROM wrapper's `en_i` / `addr_i` / `rdata_o` signals.

## Interface
- `ADDR_WIDTH`, default 10: ROM word-address width (ROM depth = 2^ADDR_WIDTH words of 32 bits).
- `BADDR_WIDTH`, default 32: requester byte-address width; must be at least ADDR_WIDTH+2.
- `clk` input 1: clock, all logic on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_i` input 2: per-port read request; held high until granted.
- `addr_i` input 2×BADDR_WIDTH: per-port byte address, packed with port p at bits `[p*BADDR_WIDTH +: BADDR_WIDTH]`.
- `gnt_o` output 2: per-port grant (combinational, same cycle as the ROM access).
- `rvalid_o` output 2: per-port response valid, one cycle after the grant.
- `rdata_o` output 2×32: per-port read data, registered, held until the next `rvalid_o` on that port.
- `err_o` output 2: per-port error, qualified by `rvalid_o`.
- `rom_en_o` output 1: ROM enable, active-high.
- `rom_addr_o` output ADDR_WIDTH: ROM word address.
- `rom_rdata_i` input 32: ROM data, valid in the cycle after `rom_en_o`.

## Operation
- Word address: `rom_addr_o = addr[ADDR_WIDTH+1:2]` of the granted port. Byte-address bits [1:0] are ignored.
- Range check: an access is out of range if any of `addr[BADDR_WIDTH-1:ADDR_WIDTH+2]` is set.
  - The access is still granted, but `rom_en_o` stays 0.
  - The response is `err_o=1`, `rdata_o=32'h0`.
- Arbitration: at most one grant per cycle.
  - Only one `req_i` high: that port is granted.
  - Both high: round-robin pointer `rr_q` picks the port. `rr_q` resets to 0 (port 0 has priority).
  - After any grant, `rr_q` moves to the other port (`rr_q <= ~granted_port`).
- `rom_en_o = |gnt_o & in_range`. `rom_addr_o` is driven from the granted port, and is 0 when there is no grant.
- Response tracking registers:
  - `resp_v_q`: a response is due this cycle.
  - `resp_port_q`: which port the response belongs to.
  - `resp_err_q`: whether the response is an error.
  - All are captured on the grant cycle.
- Response cycle, for port p = `resp_port_q`:
  - `rvalid_o[p]=1` for exactly one cycle.
  - Normal access: `rdata_q[p] <= rom_rdata_i`. Error access: `rdata_q[p] <= 0`, `err_q[p] <= 1`.
  - The other port's `rdata_q` and `err_q` are unchanged.
- Back-to-back: a new grant may be issued in the same cycle as the previous access's response, giving one access per cycle sustained. No stall state exists.
- A deasserted `req_i` without a grant is legal (request withdrawn). A withdrawn request never produces a response.

## Timing
- Reset values:
  - `gnt_o=0`, `rvalid_o=0`, `err_o=0`, `rdata_o=0` for both ports.
  - `rom_en_o=0`, `rom_addr_o=0`.
  - `rr_q=0`, `resp_v_q=0`.
- Latency: grant at cycle N gives `rvalid_o` and valid `rdata_o` / `err_o` at cycle N+1 (registered outputs valid from the N+1 edge).
  - `rdata_o` is updated at the N+1 clock edge from `rom_rdata_i`, which the ROM presents during cycle N+1.
  - The implementation therefore muxes `rom_rdata_i` straight to `rdata_o[p]` in the response cycle and holds it in `rdata_q` afterwards.
  - The verifier samples `rdata_o` when `rvalid_o` is high and again in later cycles; both samples must match.
- `gnt_o`, `rom_en_o` and `rom_addr_o` are combinational from `req_i`, `addr_i` and `rr_q`. There is no combinational path from `rom_rdata_i` to any grant signal.
- Reset mid-operation: asserting `rst_n=0` during a pending response drops that response. No `rvalid_o` appears after reset is released.
- `err_o[p]` equals `err_q[p]`. It is cleared on the next non-error response to port p.

## Test plan
- **Single port read.** Port 0 requests byte address 0x8, ROM word 2 = 0xDEADBEEF.
  - Cycle N: `gnt_o=01`, `rom_en_o=1`, `rom_addr_o=2`.
  - Cycle N+1: `rvalid_o=01`, `rdata_o[0]=0xDEADBEEF`, `err_o[0]=0`.
  - Data is held for the following 3 idle cycles.
- **Contention.** Both ports request every cycle starting from reset.
  - Grants alternate 01, 10, 01, 10.
  - Each port gets exactly one `rvalid_o` per two cycles, with the correct per-port data.
- **Out of range.** With ADDR_WIDTH=10, port 1 requests byte address 0x1000.
  - `gnt_o=10`, `rom_en_o=0`.
  - Next cycle: `rvalid_o=10`, `err_o[1]=1`, `rdata_o[1]=0`.
  - A following in-range access on port 1 clears `err_o[1]`.
- **Back-to-back streaming.** Port 0 requests addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - Four consecutive `rvalid_o[0]` pulses return words 0..3 in order.
  - `rdata_o[1]` is unchanged throughout.
- **Byte-offset ignore.** Requests to 0x5, 0x6 and 0x7 all read word 1.
- **Reset mid-access.** Grant port 1, then assert `rst_n` low before the next edge.
  - No `rvalid_o` occurs.
  - All outputs are 0.
  - The first request after reset with both ports requesting is granted to port 0.
